// File: rtl/sdds_pkg.sv
// Shared types and helpers for the dual-rail sdds pipeline: per-bit code
// classification and the clocked 2-of-2 hysteresis (C-element) update.
package sdds_pkg;

  typedef enum logic [1:0] {
    SDDS_SPACER,
    SDDS_DATA,
    SDDS_PARTIAL
  } sdds_state_e;

  // Classify one dual-rail bit; t=f=1 is illegal and never counts as complete.
  function automatic sdds_state_e sdds_complete(input logic t, input logic f);
    if (t ^ f) return SDDS_DATA;
    if (!t && !f) return SDDS_SPACER;
    return SDDS_PARTIAL;
  endfunction

  // Output rises when both inputs are 1, falls when both are 0, else holds.
  function automatic logic c2(input logic a, input logic b, input logic q);
    return (a & b) | (q & (a | b));
  endfunction

endpackage

// File: rtl/sdds_stage.sv
// One dual-rail pipeline stage: WIDTH rail pairs of clocked C-elements plus
// a completion flop that remembers the last full DATA/SPACER state.
module sdds_stage
  import sdds_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter bit               RESET_DATA = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             ck,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_t,
  input  logic [WIDTH-1:0] i_f,
  input  logic             i_rfd,
  output logic [WIDTH-1:0] o_t,
  output logic [WIDTH-1:0] o_f,
  output logic             o_ack
);

  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_f;
  logic             r_ack;
  logic             w_all_data;
  logic             w_all_spacer;

  always_comb begin
    w_all_data   = 1'b1;
    w_all_spacer = 1'b1;
    for (int b = 0; b < WIDTH; b++) begin
      if (sdds_complete(r_t[b], r_f[b]) != SDDS_DATA)   w_all_data   = 1'b0;
      if (sdds_complete(r_t[b], r_f[b]) != SDDS_SPACER) w_all_spacer = 1'b0;
    end
  end

  // A partially filled word keeps reporting the previous completion state.
  assign o_ack = w_all_data ? 1'b1 : (w_all_spacer ? 1'b0 : r_ack);
  assign o_t   = r_t;
  assign o_f   = r_f;

  always_ff @(posedge ck) begin
    if (reset) begin
      r_ack <= RESET_DATA;
      r_t   <= RESET_DATA ? RESET_VAL  : '0;
      r_f   <= RESET_DATA ? ~RESET_VAL : '0;
    end else begin
      r_ack <= o_ack;
      for (int b = 0; b < WIDTH; b++) begin
        r_t[b] <= c2(i_t[b], i_rfd, r_t[b]);
        r_f[b] <= c2(i_f[b], i_rfd, r_f[b]);
      end
    end
  end

endmodule

// File: rtl/sdds_pipe.sv
// WIDTH-bit, DEPTH-stage dual-rail clocked pipeline with per-stage completion.
// Optional sticky illegal-code flag on the input enabled by SDDS_ERR_DETECT_EN.
module sdds_pipe
  import sdds_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 3,
  parameter bit               RESET_DATA = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             ck,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_t,
  input  logic [WIDTH-1:0] d_f,
  output logic             d_ack,
  output logic [WIDTH-1:0] q_t,
  output logic [WIDTH-1:0] q_f,
  input  logic             q_ack
`ifdef SDDS_ERR_DETECT_EN
  ,
  output logic             err
`endif
);

  // Index 0 is the pipe input; index g+1 is the output of stage g.
  logic [WIDTH-1:0] w_t   [DEPTH+1];
  logic [WIDTH-1:0] w_f   [DEPTH+1];
  logic             w_ack [DEPTH+1];

  assign w_t[0]       = d_t;
  assign w_f[0]       = d_f;
  assign w_ack[DEPTH] = q_ack;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    localparam bit LAST = (g == DEPTH - 1);
    // Only the output stage can come out of reset holding a token.
    sdds_stage #(
      .WIDTH      (WIDTH),
      .RESET_DATA (LAST ? RESET_DATA : 1'b0),
      .RESET_VAL  (RESET_VAL)
    ) u_stage (
      .ck    (ck),
      .reset (reset),
      .i_t   (w_t[g]),
      .i_f   (w_f[g]),
      .i_rfd (~w_ack[g+1]),
      .o_t   (w_t[g+1]),
      .o_f   (w_f[g+1]),
      .o_ack (w_ack[g])
    );
  end

  assign d_ack = w_ack[0];
  assign q_t   = w_t[DEPTH];
  assign q_f   = w_f[DEPTH];

`ifdef SDDS_ERR_DETECT_EN
  logic r_err;

  always_ff @(posedge ck) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (|(d_t & d_f)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_sdds_pipe.sv
// Self-checking bench for sdds_pipe (WIDTH=8, DEPTH=3, reset token 8'hA5):
// directed scenarios plus randomized handshake traffic against a word-level model.
module tb_sdds_pipe;

  localparam int           W  = 8;
  localparam int           D  = 3;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         ck    = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] d_t   = '0;
  logic [W-1:0] d_f   = '0;
  logic         q_ack = 1'b0;
  logic         d_ack;
  logic [W-1:0] q_t;
  logic [W-1:0] q_f;
`ifdef SDDS_ERR_DETECT_EN
  logic         err;
`endif

  always #5 ck = ~ck;

  sdds_pipe #(
    .WIDTH      (W),
    .DEPTH      (D),
    .RESET_DATA (1'b1),
    .RESET_VAL  (RV)
  ) dut (
    .ck    (ck),
    .reset (reset),
    .d_t   (d_t),
    .d_f   (d_f),
    .d_ack (d_ack),
    .q_t   (q_t),
    .q_f   (q_f),
    .q_ack (q_ack)
`ifdef SDDS_ERR_DETECT_EN
    ,
    .err   (err)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Word-level reference: each stage holds a (t,f) word and a remembered completion.
  logic [W-1:0] m_t    [D];
  logic [W-1:0] m_f    [D];
  logic         m_done [D];
  logic         m_err = 1'b0;

  function automatic logic m_ack(input int i);
    if ((m_t[i] ^ m_f[i]) == '1) return 1'b1;
    if ((m_t[i] | m_f[i]) == '0) return 1'b0;
    return m_done[i];
  endfunction

  task automatic model_edge();
    logic [W-1:0] nt [D];
    logic [W-1:0] nf [D];
    logic         nd [D];
    logic [W-1:0] in_t, in_f;
    logic         rfd;
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        nt[i] = '0; nf[i] = '0; nd[i] = 1'b0;
      end
      nt[D-1] = RV; nf[D-1] = ~RV; nd[D-1] = 1'b1;
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < D; i++) begin
        if (i == 0) begin
          in_t = d_t; in_f = d_f;
        end else begin
          in_t = m_t[i-1]; in_f = m_f[i-1];
        end
        rfd = (i == D - 1) ? ~q_ack : ~m_ack(i + 1);
        // Ready: rails may only rise. Not ready: rails may only fall.
        if (rfd) begin
          nt[i] = m_t[i] | in_t; nf[i] = m_f[i] | in_f;
        end else begin
          nt[i] = m_t[i] & in_t; nf[i] = m_f[i] & in_f;
        end
        nd[i] = m_ack(i);
      end
      if ((d_t & d_f) != '0) m_err = 1'b1;
    end
    for (int i = 0; i < D; i++) begin
      m_t[i] = nt[i]; m_f[i] = nf[i]; m_done[i] = nd[i];
    end
  endtask

  task automatic tick();
    @(posedge ck);
    model_edge();
    #1;
    check_val("model_q_t", 32'(q_t), 32'(m_t[D-1]));
    check_val("model_q_f", 32'(q_f), 32'(m_f[D-1]));
    check_val("model_d_ack", 32'(d_ack), 32'(m_ack(0)));
`ifdef SDDS_ERR_DETECT_EN
    check_val("model_err", 32'(err), 32'(m_err));
`endif
  endtask

  logic [W-1:0] tok;
  logic [W-1:0] mask;
  logic         stall;
  int           r;

  initial begin
    // Reset with token
    reset = 1'b1; tick(); tick();
    check_val("rst_q_t", 32'(q_t), 32'h0000_00A5);
    check_val("rst_q_f", 32'(q_f), 32'h0000_005A);
    check_val("rst_d_ack", 32'(d_ack), 32'h0);
    reset = 1'b0; tick();
    check_val("rel_q_t", 32'(q_t), 32'h0000_00A5);

    // Partial word does not complete stage 0
    d_t = 8'h05; d_f = 8'h0A; tick();
    check_val("partial_d_ack", 32'(d_ack), 32'h0);
    d_t = 8'h35; d_f = 8'hCA; tick();
    check_val("complete_d_ack", 32'(d_ack), 32'h1);

    // Drain reset token, move 35 into stage 1, then reset mid-flight
    q_ack = 1'b1; tick();
    check_val("drain_q_t", 32'(q_t), 32'h0);
    check_val("drain_q_f", 32'(q_f), 32'h0);
    q_ack = 1'b0; tick();
    reset = 1'b1; d_t = '0; d_f = '0; tick();
    check_val("midrst_q_t", 32'(q_t), 32'h0000_00A5);
    check_val("midrst_q_f", 32'(q_f), 32'h0000_005A);
    check_val("midrst_d_ack", 32'(d_ack), 32'h0);
    reset = 1'b0;

    // Latency through an empty pipe
    q_ack = 1'b1; tick();
    q_ack = 1'b0;
    d_t = 8'h3C; d_f = 8'hC3; tick();
    check_val("lat1_d_ack", 32'(d_ack), 32'h1);
    check_val("lat1_q_t", 32'(q_t), 32'h0);
    tick(); tick();
    check_val("lat3_q_t", 32'(q_t), 32'h0000_003C);
    check_val("lat3_q_f", 32'(q_f), 32'h0000_00C3);
    d_t = '0; d_f = '0; q_ack = 1'b1; tick(); tick(); tick();

`ifdef SDDS_ERR_DETECT_EN
    d_t = 8'h04; d_f = 8'h04; tick();
    check_val("err_set", 32'(err), 32'h1);
    d_t = '0; d_f = '0; tick(); tick();
    check_val("err_sticky", 32'(err), 32'h1);
    reset = 1'b1; tick();
    check_val("err_rst", 32'(err), 32'h0);
    reset = 1'b0;
`endif

    // Randomized 4-phase traffic, with stall phases holding q_ack high
    tok = W'($urandom);
    for (int c = 0; c < 4000; c++) begin
      stall = ((c / 400) % 4) == 1;
      r = int'($urandom_range(0, 99));
      reset = (r < 1);
      if (r >= 97) begin
        d_t = W'($urandom); d_f = W'($urandom);
      end else if (d_ack) begin
        if ($urandom_range(0, 9) < 7) begin
          d_t = '0; d_f = '0; tok = W'($urandom);
        end
      end else if ($urandom_range(0, 9) < 6) begin
        d_t = tok; d_f = ~tok;
      end else if ($urandom_range(0, 9) < 5) begin
        mask = W'($urandom);
        d_t = tok & mask; d_f = ~tok & mask;
      end
      if (stall) q_ack = 1'b1;
      else if ($urandom_range(0, 1) == 1) begin
        if ((q_t ^ q_f) == '1) q_ack = 1'b1;
        else if ((q_t | q_f) == '0) q_ack = 1'b0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
